// File: rtl/alarm_ring_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_ring_ctrl
// Alarm clock ring sequencer. Detects the falling edge of the time-comparator
// match (match_n), rings the buzzer with a 1 s on / 1 s off cadence, and
// handles stop and snooze keys. The number of snoozes per alarm event is
// limited. Ringing stops on its own after RING_SEC seconds. After the event ends,
// the block stays in DONE until the comparator match goes away. This prevents a
// retrigger within the same matching minute.
//
// Parameters
//   RING_SEC    ring duration in seconds before auto-stop (1..65535)
//   SNOOZE_SEC  snooze pause in seconds (1..65535)
//   MAX_SNOOZE  snoozes allowed per alarm event (0..7)
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   alarm_en    alarm armed; low forces IDLE on the next edge
//   match_n     active-low "set time == current time" level
//   sec_tick    one-clk pulse per second
//   key_stop    one-clk stop press
//   key_snooze  one-clk snooze press
//   buzzer      buzzer drive, active-high
//   ringing     high in RING
//   snoozing    high in SNOOZE
//   snooze_cnt  snoozes used in the current event
//   state       IDLE=0, RING=1, SNOOZE=2, DONE=3
// -----------------------------------------------------------------------------
module alarm_ring_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alarm_en,
    input  logic       match_n,
    input  logic       sec_tick,
    input  logic       key_stop,
    input  logic       key_snooze,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [2:0] snooze_cnt,
    output logic [1:0] state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [15:0] RING_LAST   = 16'(RING_SEC - 1);
    localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SEC - 1);
    localparam logic [2:0]  SNOOZE_MAX  = 3'(MAX_SNOOZE);

    logic [1:0]  state_reg, state_next;
    logic        phase_reg, phase_next;
    logic [15:0] ring_sec_reg, ring_sec_next;
    logic [15:0] snz_sec_reg, snz_sec_next;
    logic [2:0]  snooze_cnt_reg, snooze_cnt_next;
    logic        match_q;
    logic        trigger;

    // match_q resets high so that a match that is already active at reset
    // release is treated as a fresh falling edge.
    assign trigger = alarm_en & match_q & ~match_n;

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        ring_sec_next   = ring_sec_reg;
        snz_sec_next    = snz_sec_reg;
        snooze_cnt_next = snooze_cnt_reg;

        if (!alarm_en) begin
            // Disarming overrides every other event.
            state_next      = ST_IDLE;
            phase_next      = 1'b0;
            ring_sec_next   = '0;
            snz_sec_next    = '0;
            snooze_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (trigger) begin
                        state_next    = ST_RING;
                        ring_sec_next = '0;
                        phase_next    = 1'b1;
                    end
                end
                ST_RING: begin
                    // Priority: stop, then an accepted snooze, then the second
                    // tick. An ignored snooze (limit reached) lets the tick proceed.
                    if (key_stop) begin
                        state_next = ST_DONE;
                    end else if (key_snooze && (snooze_cnt_reg < SNOOZE_MAX)) begin
                        state_next      = ST_SNOOZE;
                        snooze_cnt_next = snooze_cnt_reg + 3'd1;
                        snz_sec_next    = '0;
                    end else if (sec_tick) begin
                        if (ring_sec_reg == RING_LAST) begin
                            state_next = ST_DONE;
                        end else begin
                            ring_sec_next = ring_sec_reg + 16'd1;
                            phase_next    = ~phase_reg;
                        end
                    end
                end
                ST_SNOOZE: begin
                    // Stop wins over a snooze expiry in the same cycle.
                    if (key_stop) begin
                        state_next = ST_DONE;
                    end else if (sec_tick) begin
                        if (snz_sec_reg == SNOOZE_LAST) begin
                            state_next    = ST_RING;
                            ring_sec_next = '0;
                            phase_next    = 1'b1;
                        end else begin
                            snz_sec_next = snz_sec_reg + 16'd1;
                        end
                    end
                end
                default: begin  // ST_DONE
                    if (match_n) begin
                        state_next      = ST_IDLE;
                        phase_next      = 1'b0;
                        ring_sec_next   = '0;
                        snz_sec_next    = '0;
                        snooze_cnt_next = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            phase_reg      <= 1'b0;
            ring_sec_reg   <= '0;
            snz_sec_reg    <= '0;
            snooze_cnt_reg <= '0;
            match_q        <= 1'b1;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            ring_sec_reg   <= ring_sec_next;
            snz_sec_reg    <= snz_sec_next;
            snooze_cnt_reg <= snooze_cnt_next;
            match_q        <= match_n;
        end
    end

    // All outputs are plain decodes of registers. The reset clears them
    // immediately and they cannot glitch after release.
    assign ringing    = (state_reg == ST_RING);
    assign snoozing   = (state_reg == ST_SNOOZE);
    assign buzzer     = ringing & phase_reg;
    assign snooze_cnt = snooze_cnt_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
module tb_alarm_ring_ctrl;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RING   = 2'd1;
    localparam logic [1:0] SNOOZE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alarm_en;
    logic       match_n;
    logic       sec_tick;
    logic       key_stop;
    logic       key_snooze;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [2:0] snooze_cnt;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       buz;
        logic [2:0] sc;
    } exp_t;

    exp_t sb[$];

    alarm_ring_ctrl #(
        .RING_SEC  (4),
        .SNOOZE_SEC(6),
        .MAX_SNOOZE(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alarm_en  (alarm_en),
        .match_n   (match_n),
        .sec_tick  (sec_tick),
        .key_stop  (key_stop),
        .key_snooze(key_snooze),
        .buzzer    (buzzer),
        .ringing   (ringing),
        .snoozing  (snoozing),
        .snooze_cnt(snooze_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge. Queue the state expected
    // after the next rising edge.
    task automatic step(input logic en, input logic mn, input logic tick,
                        input logic stop, input logic snz,
                        input logic [1:0] est, input logic ebuz,
                        input logic [2:0] esc, input string tag);
        exp_t e;
        @(negedge clk);
        alarm_en   = en;
        match_n    = mn;
        sec_tick   = tick;
        key_stop   = stop;
        key_snooze = snz;
        e.tag = tag;
        e.st  = est;
        e.buz = ebuz;
        e.sc  = esc;
        sb.push_back(e);
    endtask

    // Compare each queued expectation 1 time unit after the rising edge.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_txn++;
            $display("txn %0d %s: state=%0d buzzer=%0b ringing=%0b snoozing=%0b snooze_cnt=%0d",
                     n_txn, e.tag, state, buzzer, ringing, snoozing, snooze_cnt);
            check_val({e.tag, ".state"},      32'(state),      32'(e.st));
            check_val({e.tag, ".buzzer"},     32'(buzzer),     32'(e.buz));
            check_val({e.tag, ".ringing"},    32'(ringing),    32'(e.st == RING));
            check_val({e.tag, ".snoozing"},   32'(snoozing),   32'(e.st == SNOOZE));
            check_val({e.tag, ".snooze_cnt"}, 32'(snooze_cnt), 32'(e.sc));
        end
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, ".state"},      32'(state),      32'(IDLE));
        check_val({tag, ".buzzer"},     32'(buzzer),     32'd0);
        check_val({tag, ".ringing"},    32'(ringing),    32'd0);
        check_val({tag, ".snoozing"},   32'(snoozing),   32'd0);
        check_val({tag, ".snooze_cnt"}, 32'(snooze_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; alarm_en = 1'b1; match_n = 1'b1;
        sec_tick = 1'b0; key_stop = 1'b0; key_snooze = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ring, cadence, timeout, and return to IDLE.
        step(1,1,0,0,0, IDLE,  0,0, "a_idle");
        step(1,0,0,0,0, RING,  1,0, "a_trig");
        step(1,0,1,0,0, RING,  0,0, "a_t1");
        step(1,0,1,0,0, RING,  1,0, "a_t2");
        step(1,0,1,0,0, RING,  0,0, "a_t3");
        step(1,0,1,0,0, DONE,  0,0, "a_t4_timeout");
        step(1,0,0,1,1, DONE,  0,0, "a_done_hold_keys");
        step(1,1,0,0,0, IDLE,  0,0, "a_release");

        // Snooze twice, third press ignored, timeout.
        step(1,0,0,0,0, RING,  1,0, "b_trig");
        step(1,0,0,0,1, SNOOZE,0,1, "b_snz1");
        for (int i = 1; i <= 5; i++)
            step(1,0,1,0,1, SNOOZE,0,1, $sformatf("b_s1_t%0d", i));
        step(1,0,1,0,0, RING,  1,1, "b_s1_expire");
        step(1,0,0,0,1, SNOOZE,0,2, "b_snz2");
        for (int i = 1; i <= 5; i++)
            step(1,0,1,0,0, SNOOZE,0,2, $sformatf("b_s2_t%0d", i));
        step(1,0,1,0,0, RING,  1,2, "b_s2_expire");
        step(1,0,0,0,1, RING,  1,2, "b_snz3_ignored");
        step(1,0,1,0,0, RING,  0,2, "b_t1");
        step(1,0,1,0,0, RING,  1,2, "b_t2");
        step(1,0,1,0,0, RING,  0,2, "b_t3");
        step(1,0,1,0,1, DONE,  0,2, "b_t4_timeout_snz_at_max");
        step(1,1,0,0,0, IDLE,  0,0, "b_release");

        // Stop and snooze in the same cycle. Stop wins.
        step(1,0,0,0,0, RING,  1,0, "c_trig");
        step(1,0,1,0,0, RING,  0,0, "c_t1");
        step(1,0,1,1,1, DONE,  0,0, "c_stop_snz_tick");
        step(1,1,0,0,0, IDLE,  0,0, "c_release");

        // Stop in the same cycle as snooze expiry.
        step(1,0,0,0,0, RING,  1,0, "d_trig");
        step(1,0,0,0,1, SNOOZE,0,1, "d_snz");
        for (int i = 1; i <= 5; i++)
            step(1,0,1,0,0, SNOOZE,0,1, $sformatf("d_t%0d", i));
        step(1,0,1,1,0, DONE,  0,1, "d_stop_on_expiry");
        step(1,1,0,0,0, IDLE,  0,0, "d_release");

        // Disarm during RING with snooze_cnt nonzero. Re-arm while match is held.
        step(1,0,0,0,0, RING,  1,0, "e_trig");
        step(1,0,0,0,1, SNOOZE,0,1, "e_snz");
        for (int i = 1; i <= 5; i++)
            step(1,0,1,0,0, SNOOZE,0,1, $sformatf("e_t%0d", i));
        step(1,0,1,0,0, RING,  1,1, "e_expire");
        step(0,0,1,1,1, IDLE,  0,0, "e_disarm");
        step(0,0,0,0,0, IDLE,  0,0, "e_off");
        step(1,0,0,0,0, IDLE,  0,0, "e_rearm_held");
        step(1,0,0,1,1, IDLE,  0,0, "e_keys_idle");
        step(1,1,0,0,0, IDLE,  0,0, "e_release");

        // Reset in the middle of SNOOZE.
        step(1,0,0,0,0, RING,  1,0, "f_trig");
        step(1,0,0,0,1, SNOOZE,0,1, "f_snz");
        step(1,1,1,0,0, SNOOZE,0,1, "f_t1");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("f_reset_mid_snooze");
        @(negedge clk);
        rst_n = 1'b1;
        step(1,1,0,0,0, IDLE,  0,0, "f_after_release");

        // Match already active at reset release triggers on the first edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        match_n = 1'b0;
        #1;
        check_all_zero("g_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1,0,0,0,0, RING,  1,0, "g_first_edge_trig");
        step(0,0,0,0,0, IDLE,  0,0, "g_disarm");

        @(posedge clk);
        #3;
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alarm_ring_ctrl.md
ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

Interface
REQ-001 Parameter RING_SEC, default 60, ring duration in seconds before auto-stop (range 1..65535).
REQ-002 Parameter SNOOZE_SEC, default 300, snooze pause in seconds (range 1..65535).
REQ-003 Parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event (range 0..7).
REQ-004 clk  input  1  system clock; one clock domain.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 alarm_en  input  1  alarm armed; low forces IDLE.
REQ-007 match_n  input  1  active-low level from the time comparator; 0 means set time equals current time.
REQ-008 sec_tick  input  1  one-clk pulse once per second.
REQ-009 key_stop  input  1  debounced one-clk press pulse, stop request.
REQ-010 key_snooze  input  1  debounced one-clk press pulse, snooze request.
REQ-011 buzzer  output  1  buzzer drive, active-high.
REQ-012 ringing  output  1  high while state is RING.
REQ-013 snoozing  output  1  high while state is SNOOZE.
REQ-014 snooze_cnt  output  3  snoozes used in current event.
REQ-015 state  output  2  IDLE=0, RING=1, SNOOZE=2, DONE=3.

Function
REQ-016 The block SHALL register match_n into match_q each clk; trigger = alarm_en & match_q==1 & match_n==0.
REQ-017 In IDLE, trigger SHALL move state to RING at that clk edge, clearing ring counter and setting phase=1.
REQ-018 In RING, each sec_tick SHALL toggle phase and increment the ring counter.
REQ-019 buzzer SHALL equal (state==RING) & phase, decoded from registers, zero added latency.
REQ-020 In RING, key_stop SHALL move to DONE.
REQ-021 In RING, key_snooze with snooze_cnt < MAX_SNOOZE SHALL move to SNOOZE, increment snooze_cnt, clear snooze counter.
REQ-022 In RING, key_snooze with snooze_cnt == MAX_SNOOZE SHALL be ignored.
REQ-023 In RING, sec_tick while ring counter == RING_SEC-1 SHALL move to DONE (timeout).
REQ-024 Same-cycle priority in RING: key_stop > key_snooze > timeout.
REQ-025 In SNOOZE, each sec_tick SHALL increment the snooze counter; sec_tick at SNOOZE_SEC-1 SHALL move to RING with ring counter=0, phase=1.
REQ-026 In SNOOZE, key_stop SHALL move to DONE (wins over same-cycle expiry); key_snooze ignored.
REQ-027 In DONE, state SHALL return to IDLE on the first clk with match_n==1; no retrigger while match_n stays 0.
REQ-028 alarm_en==0 SHALL force IDLE from any state at the next clk edge, overriding all other events.
REQ-029 Every entry to IDLE SHALL clear snooze_cnt, ring counter, snooze counter and phase.
REQ-030 Internal counters SHALL be 16 bits unsigned, never wrap in valid parameter range.
REQ-031 Key pulses in IDLE or DONE SHALL have no effect.

Reset
REQ-032 rst_n low SHALL immediately set state=IDLE, match_q=1, phase=0, all counters 0, snooze_cnt=0, buzzer=0, ringing=0, snoozing=0.
REQ-033 Reset mid-RING or mid-SNOOZE SHALL abort the event with no buzzer glitch after release.
REQ-034 If match_n==0 and alarm_en==1 at reset release, the first clk SHALL trigger RING (match_q reset value 1).

Verification (RING_SEC=4, SNOOZE_SEC=6, MAX_SNOOZE=2)
REQ-035 match_n 1->0, alarm_en=1, no keys -> RING next edge; buzzer pattern 1,0,1,0 across 4 ticks; DONE at 4th tick; IDLE after match_n=1.
REQ-036 RING, key_snooze x3 each after 6-tick wait -> snooze_cnt 1 then 2; third press ignored, stays RING, times out to DONE.
REQ-037 key_stop and key_snooze same cycle in RING -> DONE, snooze_cnt unchanged.
REQ-038 SNOOZE, key_stop same cycle as 6th tick -> DONE, not RING.
REQ-039 RING, alarm_en dropped -> IDLE next edge, buzzer=0, snooze_cnt=0; re-arming while match_n held 0 -> no trigger.
REQ-040 rst_n pulsed low mid-SNOOZE with match_n=1 -> all outputs 0 immediately, IDLE after release.
